// File: rtl/gf180mcu_fd_sc_mcu7t5v0__exer_pkg.sv
// Shared definitions for the standard-cell exercisers: sequencer states,
// field widths and the reference function for the 3-input NOR cell.
package gf180mcu_fd_sc_mcu7t5v0__exer_pkg;

   // Width of the mismatch counter (saturates at all-ones).
   localparam int ERR_CNT_W = 4;
   // Width of the input vector {A3,A2,A1}.
   localparam int VEC_W     = 3;
   // Width of the completed-sweep counter.
   localparam int LOOP_W    = 8;
   // Width of the per-vector settle timer (SETTLE_CYCLES is 1..15).
   localparam int SET_W     = 4;

   // Sequencer states; encodings are fixed so debug captures stay readable.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } exer_state_e;

   // Expected ZN of a NOR3 cell for a given {A3,A2,A1} vector.
   function automatic logic nor3_exp(input logic [VEC_W-1:0] vec);
      return ~(|vec);
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__satcnt.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; once the counter reaches all-ones further increments are dropped.
module gf180mcu_fd_sc_mcu7t5v0__satcnt
   import gf180mcu_fd_sc_mcu7t5v0__exer_pkg::*;
#(
   parameter int WIDTH = ERR_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear wins, otherwise count up and stick at the maximum.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register, cleared immediately by the asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_stim_chk.sv
// Stimulus/checker for a NOR3 cell under test. Walks {A3,A2,A1} through all
// eight vectors, holds each one SETTLE_CYCLES cycles, then compares ZN with
// the expected NOR value for one cycle. Keeps a sticky fail flag, the first
// failing vector and a saturating mismatch count until the next accepted START.
module gf180mcu_fd_sc_mcu7t5v0__nor3_stim_chk
   import gf180mcu_fd_sc_mcu7t5v0__exer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,   // 1..15 cycles per vector before sampling
   parameter int LOOPS         = 1    // sweeps per START, 0 = run until ABORT
) (
   input  logic                 CLK,
   input  logic                 RN,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic                 ZN,
   output logic                 A1,
   output logic                 A2,
   output logic                 A3,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 FAIL,
   output logic [VEC_W-1:0]     ERR_VEC,
   output logic [ERR_CNT_W-1:0] ERR_CNT,
   inout  wire                  VDD,
   inout  wire                  VSS
);

   localparam logic [SET_W-1:0]  SETTLE_LOAD  = SET_W'(SETTLE_CYCLES);
   localparam logic [LOOP_W-1:0] LOOPS_LIMIT  = LOOP_W'(LOOPS);
   localparam bit                LOOP_FOREVER = (LOOPS == 0);
   localparam logic [VEC_W-1:0]  VEC_LAST     = {VEC_W{1'b1}};

   // Supply pins are only present so the wrapper netlist matches the cell.
   logic unused_supply;
   assign unused_supply = VDD ^ VSS;

   exer_state_e       state_q,   state_d;
   logic [VEC_W-1:0]  vec_q,     vec_d;
   logic [SET_W-1:0]  settle_q,  settle_d;
   logic [LOOP_W-1:0] loop_q,    loop_d;
   logic [VEC_W-1:0]  a_q,       a_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic              fail_q,    fail_d;
   logic [VEC_W-1:0]  err_vec_q, err_vec_d;

   logic              start_acc;    // START taken in IDLE this cycle
   logic              mismatch_ev;  // a recorded compare failure this cycle
   logic              zn_bad;       // ZN disagrees with the driven vector
   logic [LOOP_W-1:0] loop_inc;
   logic [ERR_CNT_W-1:0] err_cnt_w;

   // Compare ZN against the reference; written as if/else so an unknown or
   // floating ZN falls into the mismatch branch rather than passing silently.
   always_comb begin
      zn_bad = 1'b1;
      if (ZN == nor3_exp(vec_q)) begin
         zn_bad = 1'b0;
      end
   end

   // Sequencer next state, vector/timer/loop bookkeeping and result capture.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      settle_d    = settle_q;
      loop_d      = loop_q;
      fail_d      = fail_q;
      err_vec_d   = err_vec_q;
      start_acc   = 1'b0;
      mismatch_ev = 1'b0;
      loop_inc    = loop_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            // ABORT has priority over START so a held abort keeps us parked.
            if (!ABORT && START) begin
               start_acc = 1'b1;
               vec_d     = '0;
               loop_d    = '0;
               settle_d  = SETTLE_LOAD;
               fail_d    = 1'b0;
               err_vec_d = '0;
               state_d   = SETTLE;
            end
         end

         SETTLE: begin
            if (ABORT) begin
               state_d = IDLE;
            end else if (settle_q <= SET_W'(1)) begin
               state_d = SAMPLE;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end

         SAMPLE: begin
            if (ABORT) begin
               // Compare of this cycle is thrown away along with the sweep.
               state_d = IDLE;
            end else begin
               mismatch_ev = zn_bad;
               if (zn_bad) begin
                  fail_d = 1'b1;
                  if (!fail_q) begin
                     err_vec_d = vec_q;
                  end
               end
               if (vec_q != VEC_LAST) begin
                  vec_d    = vec_q + 1'b1;
                  settle_d = SETTLE_LOAD;
                  state_d  = SETTLE;
               end else begin
                  loop_d = loop_inc;
                  if (LOOP_FOREVER || (loop_inc < LOOPS_LIMIT)) begin
                     vec_d    = '0;
                     settle_d = SETTLE_LOAD;
                     state_d  = SETTLE;
                  end else begin
                     state_d = FINISH;
                  end
               end
            end
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs follow the state being entered, so A, BUSY and DONE
   // change on the same edge as the state they belong to.
   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == FINISH);
      a_d    = '0;
      if ((state_d == SETTLE) || (state_d == SAMPLE)) begin
         a_d = vec_d;
      end
   end

   // State and output registers; reset returns every output to zero at once.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         settle_q  <= '0;
         loop_q    <= '0;
         a_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
         err_vec_q <= '0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         settle_q  <= settle_d;
         loop_q    <= loop_d;
         a_q       <= a_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
         err_vec_q <= err_vec_d;
      end
   end

   // Mismatch counter: cleared by an accepted START, stops at 15.
   gf180mcu_fd_sc_mcu7t5v0__satcnt #(
      .WIDTH (ERR_CNT_W)
   ) u_err_cnt (
      .clk_i  (CLK),
      .rst_ni (RN),
      .clr_i  (start_acc),
      .inc_i  (mismatch_ev),
      .cnt_o  (err_cnt_w)
   );

   assign A1      = a_q[0];
   assign A2      = a_q[1];
   assign A3      = a_q[2];
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign FAIL    = fail_q;
   assign ERR_VEC = err_vec_q;
   assign ERR_CNT = err_cnt_w;

endmodule
